// File: rtl/iterative_divider.sv
// Radix-2 restoring integer divider for the complex (mul/div) issue path.
// Handles DIV/DIVU/REM/REMU one quotient bit per cycle. Divide-by-zero and
// signed overflow bypass the iteration and finish in one cycle. Results follow
// RISC-V M semantics: the quotient truncates toward zero and the remainder
// takes the sign of the dividend.
module iterative_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  isSigned,
  input  logic                  isRem,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  flush,
  output logic                  divFree,
  output logic                  finished,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Two's-complement negation.
  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
    return ~v + DATA_WIDTH'(1);
  endfunction

  // Magnitude of an operand; only signed operands with the MSB set are negated.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                      input logic              sgn);
    return (sgn && v[DATA_WIDTH-1]) ? negate(v) : v;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  isRem_q, isRem_d;
  logic                  negQ_q, negQ_d;
  logic                  negR_q, negR_d;

  logic                  sgnA, sgnB;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic                  take;
  logic [DATA_WIDTH-1:0] fin_val;

  assign sgnA = isSigned & dividend[DATA_WIDTH-1];
  assign sgnB = isSigned & divisor[DATA_WIDTH-1];

  // The partial remainder after the shift can reach 2*|divisor|-1, so the
  // compare keeps the extra bit. When the subtract is taken the difference is
  // below |divisor| and therefore fits in DATA_WIDTH bits.
  assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
  assign take    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[DATA_WIDTH-1:0] - dvs_q;

  assign fin_val = isRem_q ? (negR_q ? negate(rem_q) : rem_q)
                           : (negQ_q ? negate(quo_q) : quo_q);

  assign divFree  = (state_q == S_FREE);
  assign finished = (state_q == S_FINISH) && !flush;
  assign result   = (state_q == S_FINISH) ? fin_val : result_q;

  // Next-state and datapath update for FREE / RUN / FINISH.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    isRem_d  = isRem_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    case (state_q)
      S_FREE: begin
        if (req && !flush) begin
          isRem_d = isRem;
          dvs_d   = magnitude(divisor, isSigned);
          if (divisor == '0) begin
            // Divide by zero: raw bit patterns, no sign fix-up.
            state_d = S_FINISH;
            quo_d   = '1;
            rem_d   = dividend;
            negQ_d  = 1'b0;
            negR_d  = 1'b0;
          end else if (isSigned && (dividend == MIN_NEG) && (divisor == '1)) begin
            // Signed overflow: quotient wraps to the dividend.
            state_d = S_FINISH;
            quo_d   = dividend;
            rem_d   = '0;
            negQ_d  = 1'b0;
            negR_d  = 1'b0;
          end else begin
            state_d = S_RUN;
            cnt_d   = CNT_LAST;
            rem_d   = '0;
            quo_d   = magnitude(dividend, isSigned);
            negQ_d  = sgnA ^ sgnB;
            negR_d  = sgnA;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_FREE;
        end else begin
          rem_d = take ? diff : shifted[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], take};
          if (cnt_q == '0) begin
            state_d = S_FINISH;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
      end
      S_FINISH: begin
        state_d = S_FREE;
        if (!flush) begin
          result_d = fin_val;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  // State and datapath registers; asynchronous reset returns the unit to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      isRem_q  <= 1'b0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      isRem_q  <= isRem_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
    end
  end

  // The scheduler must never issue into a busy unit.
  a_no_req_when_busy: assert property (@(posedge clk) disable iff (!rst) !(req && !divFree));

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases, flush/reset
// aborts and random operands, with a result/latency scoreboard.
module tb_iterative_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req = 1'b0;
  logic         isSigned = 1'b0;
  logic         isRem = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         divFree;
  logic         finished;
  logic [W-1:0] result;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] res;
    int           due;
  } sb_t;
  sb_t sb_q[$];

  iterative_divider #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .isSigned(isSigned), .isRem(isRem),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .divFree(divFree), .finished(finished), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_special(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) || (s && a == MIN_NEG && b == '1);
  endfunction

  // Reference results from language arithmetic, with RISC-V special cases.
  function automatic logic [W-1:0] model(input logic s, input logic r,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, q, m;
    if (b == '0) return r ? a : '1;
    if (s && a == MIN_NEG && b == '1) return r ? '0 : a;
    if (s) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      m  = sa % sb;
      return r ? m : q;
    end
    return r ? (a % b) : (a / b);
  endfunction

  // Scoreboard consumer: every finished pulse must match the oldest entry.
  always @(negedge clk) begin
    sb_t e;
    if (finished === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_finished", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("finish_cycle", W'(cyc), W'(e.due));
      end
    end
  end

  // Called 1ns after a rising edge; req is high for exactly this cycle (T).
  task automatic start(input logic s, input logic r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit track, input logic [W-1:0] exp);
    sb_t e;
    req = 1'b1; isSigned = s; isRem = r; dividend = a; divisor = b;
    if (track) begin
      e.res = exp;
      e.due = cyc + (is_special(s, a, b) ? 1 : W + 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Counts busy cycles from T+1 until the unit is free again, bounded.
  task automatic wait_done(input int lat, input logic [W-1:0] exp);
    int n;
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (divFree === 1'b1) done = 1;
      else n++;
    end
    check("done_in_time", W'(done), 1);
    check("busy_cycles", W'(n), W'(lat));
    @(posedge clk); #1;
    check("result_held", result, exp);
  endtask

  task automatic do_op(input logic s, input logic r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
    start(s, r, a, b, 1, exp);
    wait_done(is_special(s, a, b) ? 1 : W + 1, exp);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic s, r;

    // Reset state
    #12;
    check("rst_divFree", W'(divFree), 1);
    check("rst_finished", W'(finished), 0);
    check("rst_result", result, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed unsigned, signed and special cases
    do_op(0, 0, 32'd100, 32'd7, 32'd14);
    do_op(0, 1, 32'd100, 32'd7, 32'd2);
    do_op(1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op(1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op(1, 0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    do_op(1, 1, 32'd7, 32'hFFFF_FFFE, 32'd1);
    do_op(0, 0, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    do_op(0, 1, 32'h1234, 32'd0, 32'h1234);
    do_op(1, 1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00);
    do_op(1, 0, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
    do_op(1, 1, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
    do_op(0, 0, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
    do_op(0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    // Flush mid-RUN at T+10, then a new op at T+11
    start(0, 0, 32'd1000, 32'd7, 0, 0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_run_free", W'(divFree), 1);
    do_op(0, 0, 32'd9, 32'd3, 32'd3);

    // Flush during FINISH masks the pulse
    start(0, 0, 32'd5, 32'd0, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_finish_masked", W'(finished), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_finish_free", W'(divFree), 1);
    check("flush_finish_result", result, 32'd3);

    // req together with flush in FREE starts nothing
    req = 1'b1; flush = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    check("req_flush_free", W'(divFree), 1);
    repeat (3) begin @(posedge clk); #1; end
    check("req_flush_still_free", W'(divFree), 1);

    // Asynchronous reset mid-RUN
    start(1, 0, 32'hFFFF_FF9C, 32'd7, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_busy", W'(divFree), 0);
    #2 rst = 1'b0;
    #1;
    check("midrun_rst_divFree", W'(divFree), 1);
    check("midrun_rst_finished", W'(finished), 0);
    check("midrun_rst_result", result, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Random operands against the reference model
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      s = i[0];
      r = i[1];
      do_op(s, r, a, b, model(s, r, a, b));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", W'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
